bfp_align_pipe: RTL and testbench
=================================

BFP_ALIGN_PIPE -- requirements
Module: bfp_align_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4, number of fp16 operands aligned per beat (>=2).
REQ-002 SHALL have parameter GUARD_W, default 3, number of extra LSBs kept below the 11-bit significand.
REQ-003 SHALL have parameter MW, derived as 11+GUARD_W, the scaled significand width per lane.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1, the reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, the input beat is present.
REQ-007 SHALL have port in_ready, output, 1, the block accepts the beat this cycle.
REQ-008 SHALL have port in_data, input, 16*LANES, fp16 operands, lane i at bits [16i+15:16i].
REQ-009 SHALL have port out_valid, output, 1, the output beat is present.
REQ-010 SHALL have port out_ready, input, 1, the downstream accepts the beat.
REQ-011 SHALL have port out_sign, output, LANES, the per-lane sign, passed through.
REQ-012 SHALL have port out_exp, output, 5, the shared block exponent.
REQ-013 SHALL have port out_mant, output, MW*LANES, the aligned significands, lane i at [MW*i+MW-1:MW*i].
REQ-014 SHALL have port out_sticky, output, LANES, the OR of all bits shifted out below the guard bits.
REQ-015 SHALL have port out_special, output, 1, set when any lane has exponent field 31 (inf/NaN).

Function
REQ-016 SHALL unpack each lane: exp field 0 gives hidden bit 0 and effective exponent 1 (subnormal/zero); otherwise hidden bit 1 and effective exponent = field.
REQ-017 SHALL compute out_exp as the maximum effective exponent over all lanes, using a balanced compare tree for any LANES.
REQ-018 SHALL form each lane's significand as {hidden, frac[9:0], GUARD_W zeros} and shift it right logically by (out_exp - lane effective exponent).
REQ-019 SHALL saturate: a shift >= MW gives out_mant lane 0 and sticky = OR of the whole pre-shift significand.
REQ-020 SHALL set sticky only from bits shifted below bit 0 of the MW-bit result; a zero shift gives sticky 0.
REQ-021 SHALL pipeline in two register stages: S1 holds the unpacked lanes and the max exponent, S2 holds the shifted results; latency from accepted input to out_valid is exactly 2 cycles with no stall.
REQ-022 SHALL sustain one beat per cycle while out_ready stays high.
REQ-023 SHALL transfer on valid&&ready at both ports; no beat is lost or duplicated.
REQ-024 SHALL compute s2_adv = !s2_valid || out_ready and in_ready = !s1_valid || s2_adv (combinational, no in_valid dependency).
REQ-025 SHALL hold every output stable while out_valid && !out_ready.
REQ-026 SHALL, when S2 drains and S1 refills in the same cycle, accept the new beat without a bubble.
REQ-027 SHALL set out_special when any lane's exponent field is 31; the remaining alignment proceeds arithmetically unchanged.
REQ-028 SHALL drive out_sign, out_mant, out_exp, out_sticky and out_special as a registered copy of S2 only; no combinational path from in_data to outputs.

Reset
REQ-029 SHALL clear s1_valid and s2_valid on rst; out_valid=0 in the cycle after rst is sampled high.
REQ-030 SHALL reset all output data registers to 0.
REQ-031 SHALL discard in-flight beats when rst asserts mid-stream; in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-032 SHALL place the fp16 field widths (EXP_W=5, FRAC_W=10, BIAS=15, EXP_SPECIAL=31) in the shared package bfp_pkg.
REQ-033 SHALL instantiate the existing fp16_unpack per lane; the saturating shift-with-sticky is one sub-module, bfp_shift_sticky, instantiated LANES times.

Verification
REQ-034 SHALL check: LANES=4, GUARD_W=3, lanes {0x3C00,0x4000,0x3800,0x0000}, out_ready=1 -> 2 cycles later out_exp=16, mant {0x1000,0x2000,0x0800,0x0000}, sticky 0, special 0.
REQ-035 SHALL check: lanes {0x4000,0x0001,0x4000,0x4000} -> lane1 mant 0x0000, sticky 1 (shift 15 >= 14).
REQ-036 SHALL check: lanes {0x3C01,0x4400,0x4400,0x4400} -> lane0 shift 2, mant 0x0802, sticky 0; repeat with 0x3C07 (shift 2) -> mant 0x080E, sticky 0, and 0x3401 (shift 4) -> mant 0x0200, sticky 1.
REQ-037 SHALL check: 5 back-to-back beats, out_ready low for cycles 2-5 -> in_ready falls after 2 beats are held, outputs stable, all 5 beats emerge in order once out_ready returns.
REQ-038 SHALL check: rst pulsed one cycle with S1 and S2 full -> out_valid=0 the next cycle, no stale beat emitted, in_ready=1.
REQ-039 SHALL check: one lane 0x7C00 with the others 0x3C00 -> out_special=1, out_exp=31, other lanes shift 16 -> mant 0, sticky 1.

Source files
------------

// File: rtl/bfp_pkg.sv
// Shared fp16 field definitions and helpers for the block-floating-point aligner.
package bfp_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 5'd31;

  function automatic logic [EXP_W-1:0] max_exp(input logic [EXP_W-1:0] a,
                                               input logic [EXP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bfp_shift_sticky.sv
// Saturating logical right shift that also reports whether any set bit fell off the bottom.
module bfp_shift_sticky #(
  parameter int MW = 14
) (
  input  logic [MW-1:0] i_sig,
  input  logic [4:0]    i_shamt,
  output logic [MW-1:0] o_mant,
  output logic          o_sticky
);

  logic [MW-1:0] w_mask;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    w_mask   = '0;
    o_mant   = '0;
    o_sticky = 1'b0;
    if (32'(i_shamt) >= 32'(MW)) begin
      o_sticky = |i_sig;
    end else begin
      w_mask   = ~({MW{1'b1}} << i_shamt);
      o_mant   = i_sig >> i_shamt;
      o_sticky = |(i_sig & w_mask);
    end
  end

endmodule

// File: rtl/fp16_unpack.sv
// Splits one fp16 operand into sign, significand with hidden bit, and effective exponent.
module fp16_unpack
  import bfp_pkg::*;
(
  input  logic [15:0]       i_fp,
  output logic              o_sign,
  output logic [FRAC_W:0]   o_sig,
  output logic [EXP_W-1:0]  o_eexp,
  output logic              o_special
);

  logic [EXP_W-1:0] w_field;

  assign w_field   = i_fp[14:10];
  assign o_sign    = i_fp[15];
  // Subnormals and zero share the exponent of the smallest normal, with no hidden bit.
  assign o_sig     = {(w_field != '0), i_fp[FRAC_W-1:0]};
  assign o_eexp    = (w_field == '0) ? EXP_W'(1) : w_field;
  assign o_special = (w_field == EXP_SPECIAL);

endmodule

// File: rtl/bfp_align_pipe.sv
// Two-stage fp16 block-floating-point aligner: find the shared max exponent, then
// shift every lane's significand down to it, with valid/ready flow control.
module bfp_align_pipe
  import bfp_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int GUARD_W = 3,
  parameter int MW      = 11 + GUARD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*LANES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      out_sign,
  output logic [EXP_W-1:0]      out_exp,
  output logic [MW*LANES-1:0]   out_mant,
  output logic [LANES-1:0]      out_sticky,
  output logic                  out_special
);

  localparam int P = (LANES <= 1) ? 1 : (1 << $clog2(LANES));

  // Balanced max tree; leaves past LANES are padded with zero, which never wins.
  function automatic logic [EXP_W-1:0] tree_max(input logic [LANES-1:0][EXP_W-1:0] e);
    logic [2*P-1:0][EXP_W-1:0] t;
    t = '0;
    for (int i = 0; i < LANES; i++) t[P+i] = e[i];
    for (int n = P - 1; n >= 1; n--) t[n] = max_exp(t[2*n], t[2*n+1]);
    return t[1];
  endfunction

  logic [LANES-1:0]              w_sign;
  logic [LANES-1:0][FRAC_W:0]    w_sig;
  logic [LANES-1:0][EXP_W-1:0]   w_eexp;
  logic [LANES-1:0]              w_lane_special;
  logic                          w_s2_adv;
  logic                          w_s1_load;
  logic                          w_s2_load;

  logic                          r_s1_valid;
  logic [LANES-1:0]              r_s1_sign;
  logic [LANES-1:0][FRAC_W:0]    r_s1_sig;
  logic [LANES-1:0][EXP_W-1:0]   r_s1_eexp;
  logic [EXP_W-1:0]              r_s1_max;
  logic                          r_s1_special;

  logic [LANES-1:0][MW-1:0]      w_mant;
  logic [LANES-1:0]              w_sticky;

  logic                          r_s2_valid;
  logic [LANES-1:0]              r_out_sign;
  logic [EXP_W-1:0]              r_out_exp;
  logic [LANES-1:0][MW-1:0]      r_out_mant;
  logic [LANES-1:0]              r_out_sticky;
  logic                          r_out_special;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [4:0] w_shamt;

    fp16_unpack u_unpack (
      .i_fp      (in_data[16*g +: 16]),
      .o_sign    (w_sign[g]),
      .o_sig     (w_sig[g]),
      .o_eexp    (w_eexp[g]),
      .o_special (w_lane_special[g])
    );

    assign w_shamt = r_s1_max - r_s1_eexp[g];

    bfp_shift_sticky #(.MW(MW)) u_shift (
      .i_sig    ({r_s1_sig[g], {GUARD_W{1'b0}}}),
      .i_shamt  (w_shamt),
      .o_mant   (w_mant[g]),
      .o_sticky (w_sticky[g])
    );
  end

  // Ready depends only on pipeline occupancy, never on in_valid.
  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_adv;
  assign w_s1_load = in_ready && in_valid;
  assign w_s2_load = w_s2_adv && r_s1_valid;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  // NOTE: data registers are reset too, so outputs read as zero right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_sign    <= '0;
      r_s1_sig     <= '0;
      r_s1_eexp    <= '0;
      r_s1_max     <= '0;
      r_s1_special <= 1'b0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_s1_load) begin
        r_s1_sign    <= w_sign;
        r_s1_sig     <= w_sig;
        r_s1_eexp    <= w_eexp;
        r_s1_max     <= tree_max(w_eexp);
        r_s1_special <= |w_lane_special;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid    <= 1'b0;
      r_out_sign    <= '0;
      r_out_exp     <= '0;
      r_out_mant    <= '0;
      r_out_sticky  <= '0;
      r_out_special <= 1'b0;
    end else begin
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
      if (w_s2_load) begin
        r_out_sign    <= r_s1_sign;
        r_out_exp     <= r_s1_max;
        r_out_mant    <= w_mant;
        r_out_sticky  <= w_sticky;
        r_out_special <= r_s1_special;
      end
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_sign    = r_out_sign;
  assign out_exp     = r_out_exp;
  assign out_mant    = r_out_mant;
  assign out_sticky  = r_out_sticky;
  assign out_special = r_out_special;

endmodule

// File: tb/tb_bfp_align_pipe.sv
// Directed bench for bfp_align_pipe at LANES=4, GUARD_W=3 with hand-computed expectations.
module tb_bfp_align_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_sign;
  logic [4:0]  out_exp;
  logic [55:0] out_mant;
  logic [3:0]  out_sticky;
  logic        out_special;

  typedef struct packed {
    logic [55:0] mant;
    logic [3:0]  sticky;
    logic [3:0]  sign;
    logic [4:0]  exp;
    logic        special;
  } beat_t;

  beat_t       q[$];
  int          total = 0;
  int          bad   = 0;
  logic        s_valid;
  logic [4:0]  s_exp;
  logic [55:0] s_mant;

  bfp_align_pipe #(.LANES(4), .GUARD_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_exp     (out_exp),
    .out_mant    (out_mant),
    .out_sticky  (out_sticky),
    .out_special (out_special)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock cycle: drive at the falling edge, sample 1ns later, then let the rising edge happen.
  task automatic cycle(input logic iv, input logic [63:0] d, input logic ordy, output logic acc);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    acc     = iv && in_ready;
    s_valid = out_valid;
    s_exp   = out_exp;
    s_mant  = out_mant;
    if (out_valid && out_ready)
      q.push_back('{mant: out_mant, sticky: out_sticky, sign: out_sign,
                    exp: out_exp, special: out_special});
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++;
    if ({out_sign, out_exp, out_mant, out_sticky, out_special} !== '0) begin
      bad++;
      $display("FAIL reset_data: got exp=%h mant=%h sticky=%b sign=%b special=%b want all 0",
               out_exp, out_mant, out_sticky, out_sign, out_special);
    end
  endtask

  // Sends one beat with out_ready high and checks latency plus every output field.
  task automatic test_vector(input string name, input logic [63:0] d, input logic [4:0] e_exp,
                             input logic [55:0] e_mant, input logic [3:0] e_sticky,
                             input logic [3:0] e_sign, input logic e_special);
    logic acc;
    int   lat;
    q.delete();
    acc = 1'b0;
    lat = -1;
    for (int n = 0; n < 20 && !acc; n++) cycle(1'b1, d, 1'b1, acc);
    for (int k = 1; k <= 20 && q.size() == 0; k++) begin
      cycle(1'b0, 64'd0, 1'b1, acc);
      if (q.size() != 0) lat = k;
    end
    total++;
    if (q.size() != 1) begin
      bad++;
      $display("FAIL %s_count: got %0d beats want 1", name, q.size());
    end else begin
      total++;
      if (lat != 2) begin bad++; $display("FAIL %s_latency: got %0d want 2", name, lat); end
      total++;
      if (q[0].exp !== e_exp) begin bad++; $display("FAIL %s_exp: got %0d want %0d", name, q[0].exp, e_exp); end
      total++;
      if (q[0].mant !== e_mant) begin bad++; $display("FAIL %s_mant: got %h want %h", name, q[0].mant, e_mant); end
      total++;
      if (q[0].sticky !== e_sticky) begin bad++; $display("FAIL %s_sticky: got %b want %b", name, q[0].sticky, e_sticky); end
      total++;
      if (q[0].sign !== e_sign) begin bad++; $display("FAIL %s_sign: got %b want %b", name, q[0].sign, e_sign); end
      total++;
      if (q[0].special !== e_special) begin bad++; $display("FAIL %s_special: got %b want %b", name, q[0].special, e_special); end
    end
  endtask

  task automatic test_align();
    test_vector("basic", {16'h0000, 16'h3800, 16'h4000, 16'h3C00}, 5'd16,
                {14'h0000, 14'h0800, 14'h2000, 14'h1000}, 4'b0000, 4'b0000, 1'b0);
    test_vector("signed", {16'h3155, 16'hBC00, 16'h3C00, 16'hC000}, 5'd16,
                {14'h02AA, 14'h1000, 14'h1000, 14'h2000}, 4'b1000, 4'b0101, 1'b0);
  endtask

  task automatic test_saturate();
    test_vector("saturate", {16'h4000, 16'h4000, 16'h0001, 16'h4000}, 5'd16,
                {14'h2000, 14'h2000, 14'h0000, 14'h2000}, 4'b0010, 4'b0000, 1'b0);
  endtask

  task automatic test_sticky();
    test_vector("shift2_a", {16'h4400, 16'h4400, 16'h4400, 16'h3C01}, 5'd17,
                {14'h2000, 14'h2000, 14'h2000, 14'h0802}, 4'b0000, 4'b0000, 1'b0);
    test_vector("shift2_b", {16'h4400, 16'h4400, 16'h4400, 16'h3C07}, 5'd17,
                {14'h2000, 14'h2000, 14'h2000, 14'h080E}, 4'b0000, 4'b0000, 1'b0);
    test_vector("shift4", {16'h4400, 16'h4400, 16'h4400, 16'h3401}, 5'd17,
                {14'h2000, 14'h2000, 14'h2000, 14'h0200}, 4'b0001, 4'b0000, 1'b0);
  endtask

  task automatic test_special();
    test_vector("special", {16'h3C00, 16'h3C00, 16'h7C00, 16'h3C00}, 5'd31,
                {14'h0000, 14'h0000, 14'h2000, 14'h0000}, 4'b1101, 4'b0000, 1'b1);
  endtask

  // Beat k: lanes 0,2,3 have exponent 15+k, lane 1 stays at 1.0 and shifts by k.
  task automatic test_back_to_back();
    logic [63:0] d[5];
    logic [13:0] m1;
    logic [15:0] v;
    logic        acc;
    int          idx;
    for (int k = 0; k < 5; k++) begin
      v    = 16'h3C00 + 16'(k) * 16'h0400;
      d[k] = {v, v, 16'h3C00, v};
    end
    q.delete();
    idx = 0;
    for (int c = 1; c <= 40 && q.size() < 5; c++) begin
      cycle(idx < 5, (idx < 5) ? d[idx] : 64'd0, !(c >= 2 && c <= 5), acc);
      if (acc) idx++;
      if (c >= 3 && c <= 5) begin
        total++;
        if (acc !== 1'b0 || idx != 2) begin
          bad++;
          $display("FAIL b2b_stall_c%0d: in_ready=%b accepted=%0d want in_ready=0 accepted=2", c, acc, idx);
        end
        total++;
        if (s_valid !== 1'b1 || s_exp !== 5'd15 || s_mant !== {4{14'h2000}}) begin
          bad++;
          $display("FAIL b2b_hold_c%0d: valid=%b exp=%0d mant=%h want valid=1 exp=15 mant=%h",
                   c, s_valid, s_exp, s_mant, {4{14'h2000}});
        end
      end
    end
    total++;
    if (q.size() != 5) begin
      bad++;
      $display("FAIL b2b_count: got %0d beats want 5", q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        m1 = 14'h2000 >> k;
        total++;
        if (q[k].exp !== 5'(15 + k) || q[k].mant !== {14'h2000, 14'h2000, m1, 14'h2000} ||
            q[k].sticky !== 4'b0000) begin
          bad++;
          $display("FAIL b2b_beat%0d: got exp=%0d mant=%h sticky=%b want exp=%0d mant=%h sticky=0000",
                   k, q[k].exp, q[k].mant, q[k].sticky, 15 + k, {14'h2000, 14'h2000, m1, 14'h2000});
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic acc;
    int   n_acc;
    q.delete();
    n_acc = 0;
    for (int c = 0; c < 2; c++) begin
      cycle(1'b1, {4{16'h3C00}}, 1'b0, acc);
      if (acc) n_acc++;
    end
    total++;
    if (n_acc != 2) begin bad++; $display("FAIL midrst_fill: accepted %0d want 2", n_acc); end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    for (int c = 0; c < 5; c++) cycle(1'b0, 64'd0, 1'b1, acc);
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL midrst_stale: got %0d beats want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_align();
    test_saturate();
    test_sticky();
    test_special();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
